// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg : shared UART states, line levels and parity helper       |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package uart_pkg;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eight_bit_parity_generator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | eight_bit_parity_generator : byte -> {even parity, byte}           |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module eight_bit_parity_generator
  import uart_pkg::*;
(
  input  logic [7:0] data_in,
  output logic [8:0] frame_out
);

  assign frame_out = {even_parity(data_in), data_in};

endmodule
`default_nettype wire

// File: rtl/uart_parity_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_parity_tx : 8E1 UART transmitter with registered line outputs |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module uart_parity_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);
  import uart_pkg::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             tx_serial_q, tx_serial_d;
  logic             tx_busy_q, tx_busy_d;
  logic             tx_done_q, tx_done_d;
  logic [8:0]       frame_w;
  logic             last_cycle_w;

  eight_bit_parity_generator u_parity_gen (
    .data_in   (tx_data),
    .frame_out (frame_w)
  );

  assign last_cycle_w = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tx_serial_q <= IDLE_LEVEL;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tx_serial_q <= tx_serial_d;
      tx_busy_q   <= tx_busy_d;
      tx_done_q   <= tx_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    if (state_q == IDLE) begin
      if (tx_start) begin
        state_d   = START;
        cnt_d     = '0;
        bit_idx_d = '0;
        shift_d   = frame_w[7:0];
        parity_d  = frame_w[8];
      end
    end else if (last_cycle_w) begin
      cnt_d = '0;
      case (state_q)
        START: begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
        DATA: begin
          if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = PARITY;
          else                                 bit_idx_d = bit_idx_q + 3'd1;
        end
        PARITY:  state_d = STOP;
        default: state_d = IDLE;
      endcase
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Outputs are decoded from the next state so the line changes on the same edge as the state.
  always_comb begin
    tx_serial_d = IDLE_LEVEL;
    case (state_d)
      START:   tx_serial_d = START_LEVEL;
      DATA:    tx_serial_d = shift_d[bit_idx_d];
      PARITY:  tx_serial_d = parity_d;
      STOP:    tx_serial_d = STOP_LEVEL;
      default: tx_serial_d = IDLE_LEVEL;
    endcase
    tx_busy_d = (state_d != IDLE);
    tx_done_d = (state_q == STOP) && last_cycle_w;
  end

  assign tx_serial = tx_serial_q;
  assign tx_busy   = tx_busy_q;
  assign tx_done   = tx_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_parity_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_parity_tx : scoreboard bench for uart_parity_tx            |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_uart_parity_tx;

  localparam int C     = 4;
  localparam int FRAME = 11 * C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_serial, tx_busy, tx_done;

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         exp_done = 0;
  bit         mon_en = 1'b0;
  bit         abort_expected = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_parity_tx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference line image: bit 0 is the start bit, bit 10 the stop bit.
  function automatic logic [10:0] model_line(input logic [7:0] d);
    int   ones = 0;
    logic p;
    for (int k = 0; k < 8; k++) ones += int'(d[k]);
    p = ((ones % 2) == 1);
    return {1'b1, p, d, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (mon_en && tx_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Monitor: captures each frame off the line and compares with the scoreboard.
  initial begin
    logic [10:0] line;
    logic [7:0]  exp_b;
    bit          aborted, glitch, early_done;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (tx_serial === 1'b0) begin
        line = '1; aborted = 1'b0; glitch = 1'b0; early_done = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
          if (i > 0) @(negedge clk);
          if (tx_busy !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (tx_done !== 1'b0) early_done = 1'b1;
          if (i % C == 0) line[i / C] = tx_serial;
          else if (tx_serial !== line[i / C]) glitch = 1'b1;
        end
        if (aborted) begin
          if (abort_expected) begin
            abort_expected = 1'b0;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
          end else begin
            check("busy_held", tx_busy, 1'b1);
          end
          continue;
        end
        check("bit_hold_glitch", glitch, 1'b0);
        check("done_inside_frame", early_done, 1'b0);
        @(negedge clk);
        check("done_pulse", {tx_done, tx_busy, tx_serial}, 3'b101);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got line %03h, expected no frame", line);
        end else begin
          exp_b = exp_q.pop_front();
          check("frame_line", line, model_line(exp_b));
        end
      end
    end
  end

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(posedge clk);
    exp_q.push_back(d);
    exp_done++;
    @(negedge clk);
    tx_start = 1'b0;
    check("accept_latency", {tx_busy, tx_serial}, 2'b10);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (tx_busy === 1'b0) return;
      @(negedge clk);
    end
    check("idle_timeout", tx_busy, 1'b0);
  endtask

  // Drives random ignored requests while busy; releases tx_start before the idle edge.
  task automatic busy_noise();
    for (int i = 0; i < 200; i++) begin
      if (tx_busy !== 1'b1) begin
        tx_start = 1'b0;
        return;
      end
      tx_start = 1'($urandom_range(0, 1));
      tx_data  = 8'($urandom);
      @(negedge clk);
    end
    tx_start = 1'b0;
    check("noise_timeout", tx_busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset and idle line
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {tx_serial, tx_busy, tx_done}, 3'b100);
    rst = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_line", {tx_serial, tx_busy, tx_done}, 3'b100);
    end

    // Even and odd parity bytes
    send(8'hA5);
    wait_idle();
    send(8'h07);
    wait_idle();

    // Request while busy is ignored, data change after acceptance has no effect
    send(8'h3C);
    repeat (9) @(negedge clk);
    tx_data  = 8'hFF;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'h00;
    wait_idle();
    repeat (60) @(negedge clk);
    check("single_done", done_cnt, exp_done);

    // Back-to-back with tx_start held high
    @(negedge clk);
    tx_data  = 8'h01;
    tx_start = 1'b1;
    @(posedge clk);
    exp_q.push_back(8'h01);
    exp_done++;
    @(negedge clk);
    tx_data = 8'h80;
    for (int i = 0; i < 100; i++) begin
      if (tx_done === 1'b1) break;
      @(negedge clk);
    end
    check("b2b_done_seen", tx_done, 1'b1);
    @(posedge clk);
    exp_q.push_back(8'h80);
    exp_done++;
    @(negedge clk);
    tx_start = 1'b0;
    check("b2b_no_gap", {tx_busy, tx_serial}, 2'b10);
    wait_idle();

    // Reset during data bit 3 aborts the frame
    send(8'hF0);
    repeat (16) @(negedge clk);
    abort_expected = 1'b1;
    exp_done--;
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", {tx_serial, tx_busy, tx_done}, 3'b100);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("abort_no_done", done_cnt, exp_done);
    check("abort_idle_line", {tx_serial, tx_busy}, 2'b10);
    send(8'h55);
    wait_idle();

    // Randomized bytes with random ignored requests during each frame
    for (int n = 0; n < 10; n++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send(8'($urandom));
      busy_noise();
      wait_idle();
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("done_count", done_cnt, exp_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_parity_tx.md
Name: uart_parity_tx

Overview:
- Serial UART transmitter. It frames 8-bit bytes with an even-parity bit, which is the generating side of the 9-bit {parity, data} format the receive-path parity checker consumes.
- It sits between the byte source (host logic) and the tx line pin, and is the transmit counterpart of the receiver chain.
- The parity bit is the XOR of the 8 data bits, so the checker accepts every frame this block sends.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200). Must be >= 2.
- DATA_BITS, 8, payload width. Fixed at 8; the parameter exists for the package constant only.

Ports:
- clk  input  1  system clock; everything is on posedge.
- rst  input  1  synchronous, active-high reset.
- tx_start  input  1  request to send tx_data; sampled only in IDLE.
- tx_data  input  8  byte to transmit; captured in the cycle tx_start is accepted.
- tx_serial  output  1  serial line; idles high.
- tx_busy  output  1  high from the cycle after acceptance through the last stop-bit cycle.
- tx_done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset (rst high at a posedge):
  - Next cycle: tx_serial=1, tx_busy=0, tx_done=0.
  - State=IDLE; clock counter, bit index and shift register cleared.
  - Reset overrides tx_start in the same cycle.
- Frame format, 11 bits total, each held exactly CLKS_PER_BIT cycles:
  - start (0)
  - data[0]..data[7], LSB first
  - parity = ^data
  - stop (1)
- State machine: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: tx_serial=1, tx_busy=0. If tx_start=1, capture tx_data plus the generated parity, go to START.
  - START: tx_serial=0 for CLKS_PER_BIT cycles.
  - DATA: tx_serial=shift[bit_idx]. bit_idx counts 0..7; after bit 7's last cycle, go to PARITY.
  - PARITY: tx_serial=stored parity bit.
  - STOP: tx_serial=1. After the last cycle, go to IDLE and pulse tx_done.
- Latency:
  - tx_start sampled high at edge N -> tx_serial=0 and tx_busy=1 from cycle N+1.
  - Stop bit ends at N+11*CLKS_PER_BIT.
  - tx_done is high in the first IDLE cycle (N+11*CLKS_PER_BIT+1).
- Clock counter:
  - Width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1.
  - On terminal count it wraps to 0 and advances the bit or state.
  - It never exceeds CLKS_PER_BIT-1.
- Input handling:
  - tx_start while tx_busy=1 is ignored (no queueing).
  - tx_data changes after acceptance have no effect on the frame in flight.
- Back-to-back: tx_start high in the IDLE cycle where tx_done=1 is accepted. The next start bit follows immediately, with no extra idle bit time.
- Reset mid-frame aborts the frame:
  - Line returns high the next cycle.
  - No tx_done is generated.
  - The partial frame is not resumed.
- Registered outputs: tx_serial, tx_busy and tx_done are all registered, with no combinational path from inputs.

Decomposition:
- Package uart_pkg:
  - State enum tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Constants DATA_BITS=8, START_LEVEL=1'b0, STOP_LEVEL=1'b1, IDLE_LEVEL=1'b1.
  - Function even_parity(byte). The receive side reuses both the constants and the function.
- One sub-module: eight_bit_parity_generator. It takes an 8-bit input and outputs the 9-bit {^data, data}, mirroring the checker's frame layout.
  - The FSM loads its output into the shift/parity registers at acceptance.

Test Plan:
All scenarios use CLKS_PER_BIT=4, so one frame is 44 cycles.
1. Reset: hold rst 3 cycles, then release -> tx_serial=1, tx_busy=0, tx_done=0. The idle line stays 1 for 20 cycles with tx_start=0.
2. Even-parity byte 8'hA5, one-cycle tx_start pulse:
   - Line bits (each 4 cycles) 0, 1,0,1,0,0,1,0,1, 0, 1.
   - tx_busy high for 44 cycles; tx_done pulse at cycle 45.
3. Odd-count byte 8'h07 -> bits 0, 1,1,1,0,0,0,0,0, parity 1, stop 1. Loop the captured 9 bits into the parity checker -> DataOut=8'h07.
4. Busy-ignore:
   - Send 8'h3C.
   - At cycle 10, pulse tx_start with tx_data=8'hFF and also change tx_data.
   - Required: the frame is still 8'h3C (parity 0), only one tx_done, and no second frame.
5. Back-to-back: hold tx_start=1 with 8'h01 then 8'h80 -> second start bit begins the cycle after tx_done. Total 88 busy cycles plus one IDLE gap cycle; parities 1 and 1.
6. Reset mid-frame: assert rst during data bit 3 of 8'hF0 -> next cycle tx_serial=1, tx_busy=0, no tx_done. A following tx_start of 8'h55 produces a clean frame with parity 0.
